// File: rtl/twos_decode.sv
// Bit-serial two's complement to sign-magnitude decoder, LSB first, one bit per clock.
// Optional OVF output (result does not fit sign-magnitude) enabled by defining TWOS_DEC_OVF_EN.
module twos_decode (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] IN_NUM,
  output logic       BUSY,
  output logic       DONE,
  output logic       SIGN,
`ifdef TWOS_DEC_OVF_EN
  output logic       OVF,
`endif
  output logic [7:0] MAG
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] w;
  logic [DATA_W-1:0] w_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              seen;
  logic              sign_r;
  logic              out_bit;
  logic              accept;
  logic              last_bit;

  // Serial negation: copy bits up to and including the first one, invert the rest.
  function automatic logic dec_bit(input logic neg, input logic seen_one, input logic b);
    return (neg && seen_one) ? ~b : b;
  endfunction

  assign accept   = START && (state != SHIFT);
  assign last_bit = (state == SHIFT) && (cnt == CNT_W'(DATA_W - 1));
  assign out_bit  = dec_bit(sign_r, seen, sr[0]);
  assign w_nxt    = {out_bit, w[DATA_W-1:1]};

  assign BUSY = (state == SHIFT);
  assign DONE = (state == FIN);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = FIN;
      FIN:     state_nxt = START ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Serial datapath; results are written only on the final bit edge so they hold otherwise.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sr     <= '0;
      w      <= '0;
      cnt    <= '0;
      seen   <= 1'b0;
      sign_r <= 1'b0;
      SIGN   <= 1'b0;
      MAG    <= '0;
`ifdef TWOS_DEC_OVF_EN
      OVF    <= 1'b0;
`endif
    end else if (accept) begin
      sr     <= IN_NUM;
      sign_r <= IN_NUM[DATA_W-1];
      w      <= '0;
      cnt    <= '0;
      seen   <= 1'b0;
    end else if (state == SHIFT) begin
      sr   <= {1'b0, sr[DATA_W-1:1]};
      w    <= w_nxt;
      cnt  <= cnt + CNT_W'(1);
      seen <= seen | (sign_r & sr[0]);
      if (last_bit) begin
        MAG  <= w_nxt;
        SIGN <= sign_r;
`ifdef TWOS_DEC_OVF_EN
        OVF  <= w_nxt[DATA_W-1];
`endif
      end
    end
  end

endmodule
